nfifo_reader: RTL and testbench
===============================

Name: nfifo_reader

Overview:
- Read-side drain engine for the 12-bit sample FIFO (nFIFO-class buffers with empty flag, rd_en, and 1-cycle registered read data).
- Pops words from the FIFO and presents them to a downstream consumer on a valid/ready stream.
- A 2-entry skid buffer absorbs the read latency, so a continuously ready consumer sees 1 word/cycle.
- Also counts words delivered.

Parameters:
- WIDTH, 12, data word width.
- CNT_W, 16, width of delivered-word counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  permits issuing new FIFO reads; does not stop drain of data already fetched.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO pop strobe, combinational.
- out_data  out  WIDTH  stream data (head of skid buffer).
- out_valid  out  1  stream valid.
- out_ready  in  1  consumer ready.
- word_count  out  CNT_W  number of accepted stream transfers, modulo 2^CNT_W.
- busy  out  1  high when any word is buffered or in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - occupancy=0, inflight=0, out_valid=0, out_data=0, word_count=0, busy=0.
  - fifo_rd_en=0 while reset is low.
- Internal state:
  - occ in {EMPTY(0), ONE(1), TWO(2)}.
  - inflight flag = fifo_rd_en registered (1 = word arrives on fifo_dout this cycle).
- pop = out_valid && out_ready.
- fifo_rd_en = enable && !fifo_empty && (occ + inflight - pop) <= 1.
  - Never exceeds 2 committed slots.
  - Never asserted when fifo_empty=1.
- Arrival: when inflight=1, fifo_dout is written into the skid buffer at the tail on that edge.
- Occupancy update per edge: occ_next = occ + inflight - pop.
  - EMPTY→ONE on arrival without pop.
  - ONE→TWO on arrival without pop.
  - ONE→EMPTY on pop without arrival.
  - TWO→ONE on pop without arrival.
  - Arrival+pop keeps state, with the head advancing.
  - Arrival in TWO without pop is impossible by the rd_en rule; assert in simulation.
- Output:
  - out_valid = (occ != EMPTY).
  - out_data = head entry.
  - out_data holds stable while out_valid && !out_ready.
- Ordering: strict FIFO order; no word dropped or duplicated.
- Latency:
  - First fifo_rd_en occurs in the same cycle fifo_empty falls (if enable=1).
  - out_valid rises 2 edges later: the read edge, then the arrival edge.
- Throughput: with out_ready held 1 and the FIFO non-empty, steady state is one pop and one read per cycle.
- word_count increments by 1 on each pop edge and wraps from 2^CNT_W-1 to 0.
- busy = out_valid || inflight.
- enable low mid-stream: no new reads; in-flight word still lands; buffered words still drain; out_valid drops once occ=0.
- FIFO empties mid-stream: reads stop; buffered words drain normally.
- out_ready=0 for a long stall: occ reaches TWO and reads stop; no overflow.
- Reset asserted mid-operation: all state clears immediately; an in-flight word is discarded.

Test Plan:
- Ready-path throughput: reset, FIFO preloaded with 1..50, enable=1, out_ready=1.
  - fifo_rd_en first high in cycle 0.
  - out_valid high from cycle 2.
  - out_data = 1,2,…,50 on consecutive cycles.
  - word_count=50.
  - busy=0 after the last pop.
- Backpressure: FIFO holds 10,11,12,13; out_ready=0 for 6 cycles, then 1.
  - Exactly 2 fifo_rd_en pulses during the stall.
  - out_data holds 10 with out_valid=1.
  - After release, out_data sequence is 10,11,12,13 with no gaps.
- Alternating ready: out_ready toggles every cycle; FIFO holds 0x001..0x008.
  - All 8 words are delivered in order.
  - occ never exceeds 2.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Enable drop: stream 1..20; deassert enable after 5 pops.
  - At most 2 further words are delivered (6,7).
  - Then out_valid=0 and busy=0.
  - Re-enabling resumes with 8.
- Async reset mid-transfer: assert reset low between clock edges while occ=TWO.
  - out_valid, word_count, busy and fifo_rd_en go 0 immediately, without waiting for a clock edge.
  - After release, the next delivered word is the FIFO head.
- Counter wrap: CNT_W=4; deliver 17 words.
  - word_count reads 1.

Source files
------------

// File: rtl/nfifo_reader.sv
// Read-side drain engine: pops a 1-cycle-latency FIFO into a 2-entry skid buffer
// and presents the words on a valid/ready stream, counting delivered words.
module nfifo_reader #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t             occ;
  logic             inflight_p1;
  logic [WIDTH-1:0] head_p2;
  logic [WIDTH-1:0] tail_p2;
  logic             pop;
  logic [1:0]       committed;

  assign out_valid = (occ != EMPTY);
  assign out_data  = head_p2;
  assign pop       = out_valid && out_ready;
  assign busy      = out_valid || inflight_p1;

  // Slots still owed after this edge; a new read is allowed only if one stays free.
  always_comb begin
    committed = 2'(occ) + 2'(inflight_p1) - 2'(pop);
  end

  // Gated by reset so no pop strobe escapes while the block is held in reset.
  assign fifo_rd_en = reset && enable && !fifo_empty && (committed <= 2'd1);

  // Stage p1: read issued last cycle, word arrives on fifo_dout now.
  // Stage p2: skid buffer, head feeds the stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ         <= EMPTY;
      inflight_p1 <= 1'b0;
      head_p2     <= '0;
      tail_p2     <= '0;
      word_count  <= '0;
    end else begin
      inflight_p1 <= fifo_rd_en;
      if (pop) begin
        word_count <= word_count + CNT_W'(1);
      end
      case ({inflight_p1, pop})
        2'b10: begin
          if (occ == EMPTY) begin
            head_p2 <= fifo_dout;
            occ     <= ONE;
          end else begin
            tail_p2 <= fifo_dout;
            occ     <= TWO;
          end
        end
        2'b01: begin
          if (occ == TWO) begin
            head_p2 <= tail_p2;
            occ     <= ONE;
          end else begin
            occ     <= EMPTY;
          end
        end
        2'b11: begin
          if (occ == TWO) begin
            head_p2 <= tail_p2;
            tail_p2 <= fifo_dout;
          end else begin
            head_p2 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // A word landing on a full buffer with no pop would be lost.
  assert property (@(posedge clk) disable iff (!reset)
                   !(inflight_p1 && !pop && occ == TWO))
    else $error("nfifo_reader: skid buffer overflow");

endmodule

// File: tb/tb_nfifo_reader.sv
// Directed bench for nfifo_reader: FIFO model feeds the DUT, a scoreboard queue
// holds expected stream words, a CNT_W=4 twin instance covers counter wrap.
module tb_nfifo_reader;
  localparam int W = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_dout = '0;
  logic          out_ready = 1'b0;
  logic          fifo_rd_en, out_valid, busy;
  logic [W-1:0]  out_data;
  logic [15:0]   word_count;
  logic          rd4, valid4, busy4;
  logic [W-1:0]  data4;
  logic [3:0]    wc4;

  nfifo_reader #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .word_count(word_count), .busy(busy)
  );

  nfifo_reader #(.WIDTH(W), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(rd4), .out_data(data4),
    .out_valid(valid4), .out_ready(out_ready), .word_count(wc4), .busy(busy4)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc, nrd, npop, first_rd, first_vld, last_pop;
  logic [W-1:0] last_data;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(W'(first + i));
      exp_q.push_back(W'(first + i));
    end
    fifo_empty = (fq.size() == 0);
  endtask

  // One clock cycle: sample just after the falling edge, then advance the FIFO model.
  task automatic tick();
    logic rd, pp;
    #1;
    rd = fifo_rd_en;
    pp = out_valid && out_ready;
    check("rd_while_empty", {31'd0, rd && fifo_empty}, 32'd0);
    check("twin_match", {rd4, valid4, busy4, data4}, {fifo_rd_en, out_valid, busy, out_data});
    if (rd && first_rd < 0) first_rd = cyc;
    if (out_valid && first_vld < 0) first_vld = cyc;
    if (pp) begin
      if (exp_q.size() == 0) check("unexpected_word", 32'd1, 32'd0);
      else check("stream_data", out_data, exp_q.pop_front());
      npop++;
      last_pop = cyc;
      last_data = out_data;
    end
    if (rd) nrd++;
    check("occ_le2", {31'd0, (nrd - npop) <= 2}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (rd && fq.size() > 0) fifo_dout = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int k = 0;
    while (npop < target && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_budget"}, {31'd0, npop >= target}, 32'd1);
  endtask

  task automatic clear_model();
    fq.delete();
    exp_q.delete();
    cyc = 0; nrd = 0; npop = 0;
    first_rd = -1; first_vld = -1; last_pop = -1;
  endtask

  // Reset with enable high and FIFO non-empty to prove the strobe is gated.
  task automatic do_reset();
    enable = 1'b1;
    fifo_empty = 1'b0;
    out_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", word_count, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_data", out_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    fifo_empty = 1'b1;
    clear_model();
  endtask

  initial begin
    int p0;
    logic [W-1:0] head_exp;

    // Ready-path throughput
    do_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    preload(1, 50);
    run_until(50, 80, "thru");
    check("thru_first_rd", first_rd, 32'd0);
    check("thru_first_vld", first_vld, 32'd2);
    check("thru_last_pop", last_pop, 32'd51);
    #1;
    check("thru_count", word_count, 32'd50);
    check("thru_count4", wc4, 32'd2);
    check("thru_busy_end", {31'd0, busy}, 32'd0);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    preload(10, 4);
    repeat (6) tick();
    check("bp_stall_reads", nrd, 32'd2);
    #1;
    check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
    check("bp_stall_data", out_data, 32'd10);
    out_ready = 1'b1;
    p0 = cyc;
    run_until(4, 20, "bp");
    check("bp_no_gap", last_pop, p0 + 3);

    // Alternating ready
    do_reset();
    out_ready = 1'b0;
    preload(1, 8);
    for (int k = 0; k < 60 && npop < 8; k++) begin
      out_ready = ~out_ready;
      tick();
    end
    check("alt_pops", npop, 32'd8);
    #1;
    check("alt_count", word_count, 32'd8);

    // Enable drop and resume
    do_reset();
    out_ready = 1'b1;
    preload(1, 20);
    run_until(5, 20, "en");
    enable = 1'b0;
    repeat (6) tick();
    check("en_drop_pops", npop, 32'd7);
    check("en_drop_last", last_data, 32'd7);
    #1;
    check("en_drop_valid", {31'd0, out_valid}, 32'd0);
    check("en_drop_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    run_until(8, 10, "en_resume");
    check("en_resume_word", last_data, 32'd8);

    // Asynchronous reset while the buffer is full
    do_reset();
    out_ready = 1'b1;
    preload(1, 8);
    run_until(2, 10, "ar");
    out_ready = 1'b0;
    repeat (3) tick();
    #1;
    check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    check("ar_pre_count", word_count, 32'd2);
    check("ar_pre_full", nrd - npop, 32'd2);
    #1;
    reset = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_count", word_count, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    head_exp = fq[0];
    exp_q = fq;
    nrd = 0; npop = 0;
    out_ready = 1'b1;
    run_until(1, 10, "ar_resume");
    check("ar_head_word", last_data, head_exp);

    // Counter wrap on the 4-bit instance
    do_reset();
    out_ready = 1'b1;
    preload(1, 17);
    run_until(17, 40, "wrap");
    #1;
    check("wrap_count4", wc4, 32'd1);
    check("wrap_count16", word_count, 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (tests %0d)", n_tests);
    $fatal(1, "timeout");
  end

endmodule
